// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: width codes, FSM states,
// requester slots and a small sizing helper.
package mem_bus_pkg;

  // Access width encodings carried on req_width / mem_width
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  // Requester slot assignment (slot 0 wins ties after reset)
  localparam int REQ_DMA = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_SND = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Bits needed to index n items, never less than one
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Rotating priority encoder: picks the first set request at or after ptr,
// wrapping around, and returns it one-hot.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] sel_o,
  output logic            valid_o
);

  // Scan NREQ slots starting from ptr; first hit wins
  always_comb begin
    int   idx;
    logic found;
    sel_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        sel_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter: round-robin grant among NREQ requesters, two-phase
// (setup, then strobe) access sequencing, registered read-data return and
// a bounded lock so a DMA burst can keep the bus for back-to-back accesses.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   lock_i,
  input  logic [NREQ-1:0]   req_we_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  input  logic [NREQ*2-1:0] req_width_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [DW-1:0]     rdata_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [1:0]        mem_width_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_ok_i
);

  localparam int PW = ptr_w(NREQ);
  localparam int CW = ptr_w(MAX_LOCK);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      width_q, width_d;
  logic            we_q, we_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;

  logic [NREQ-1:0] pick_sel;
  logic            pick_valid;
  logic [NREQ-1:0] ld_sel;
  logic            owner_lock, owner_req, burst_room;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i  (req_i),
    .ptr_i  (rr_ptr_q),
    .sel_o  (pick_sel),
    .valid_o(pick_valid)
  );

  // Owner's live lock/req as seen at the completion edge
  assign owner_lock = |(lock_i & gnt_q);
  assign owner_req  = |(req_i & gnt_q);
  assign burst_room = (int'(lock_cnt_q) < (MAX_LOCK - 1));

  // Next-state: grant, strobe sequencing, completion and release/extend
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    we_d       = we_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    ld_sel     = '0;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_sel;
          ld_sel  = pick_sel;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Address has been stable for a full cycle; raise the strobe
        if (we_q) begin
          write_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          read_d  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        read_d  = (state_q == ST_READ);
        write_d = (state_q == ST_WRITE);
        if (mem_ok_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ack_d   = gnt_q;
          if (state_q == ST_READ) rdata_d = mem_rdata_i;
          if (owner_lock && owner_req && burst_room) begin
            // Locked burst: skip IDLE, latch the owner's next access
            lock_cnt_d = lock_cnt_q + CW'(1);
            ld_sel     = gnt_q;
            state_d    = ST_SETUP;
          end else begin
            gnt_d      = '0;
            lock_cnt_d = '0;
            state_d    = ST_IDLE;
            for (int i = 0; i < NREQ; i++)
              if (gnt_q[i]) rr_ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
          end
        end
      end
    endcase

    // Capture the selected requester's access into the memory-side regs
    for (int i = 0; i < NREQ; i++) begin
      if (ld_sel[i]) begin
        addr_d  = req_addr_i[i*AW +: AW];
        wdata_d = req_wdata_i[i*DW +: DW];
        width_d = req_width_i[i*2 +: 2];
        we_d    = req_we_i[i];
      end
    end
  end

  // FSM and output registers; reset aborts any access immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      we_q       <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      we_q       <= we_d;
      read_q     <= read_d;
      write_q    <= write_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_width_o = width_q;
  assign mem_read_o  = read_q;
  assign mem_write_o = write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference
// model compared against the outputs every cycle.
module tb_mem_bus_arbiter;
  localparam int NREQ = 3, AW = 32, DW = 32, MAX_LOCK = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0, lock = '0, req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ*2-1:0]  req_width = '0;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic [1:0]         mem_width;
  logic               mem_read, mem_write, mem_ok = 1'b1;

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Memory contents: one fixed word, everything else derived from address
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 32'h4) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction
  assign mem_rdata = mem_f(mem_addr);

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_width_i(req_width),
    .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_width_o(mem_width), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .mem_ok_i(mem_ok)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 bus free, 1 address cycle, 2 strobe held until mem_ok
  int m_phase = 0, m_owner = -1, m_ptr = 0, m_burst = 0;
  logic [NREQ-1:0] e_gnt = '0, e_ack = '0;
  logic [DW-1:0]   e_rdata = '0, e_wdata = '0;
  logic [AW-1:0]   e_addr = '0;
  logic [1:0]      e_width = '0;
  logic            e_we = 1'b0, e_read = 1'b0, e_write = 1'b0;

  task automatic m_take(input int i);
    e_addr  = req_addr[i*AW +: AW];
    e_wdata = req_wdata[i*DW +: DW];
    e_width = req_width[i*2 +: 2];
    e_we    = req_we[i];
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_owner = -1; m_ptr = 0; m_burst = 0;
      e_gnt = '0; e_ack = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
      e_width = '0; e_we = 1'b0; e_read = 1'b0; e_write = 1'b0;
    end else begin
      e_ack = '0;
      if (m_phase == 0) begin
        for (int k = 0; k < NREQ; k++)
          if (m_phase == 0 && req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_take(m_owner);
            e_gnt = '0; e_gnt[m_owner] = 1'b1;
            m_phase = 1;
          end
      end else if (m_phase == 1) begin
        e_read = !e_we; e_write = e_we; m_phase = 2;
      end else if (mem_ok) begin
        e_read = 1'b0; e_write = 1'b0;
        e_ack[m_owner] = 1'b1;
        if (!e_we) e_rdata = mem_f(e_addr);
        if (lock[m_owner] && req[m_owner] && m_burst < MAX_LOCK - 1) begin
          m_burst++; m_take(m_owner); m_phase = 1;
        end else begin
          m_ptr = (m_owner + 1) % NREQ; m_burst = 0; m_owner = -1;
          e_gnt = '0; m_phase = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("gnt", gnt, e_gnt);
      chk("ack", ack, e_ack);
      chk("rdata", rdata, e_rdata);
      chk("mem_read", mem_read, e_read);
      chk("mem_write", mem_write, e_write);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_width", mem_width, e_width);
      chk("strobe_excl", mem_read & mem_write, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] w);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_width[i*2 +: 2] = w;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; req = '0; lock = '0; mem_ok = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int nack, cyc, last, gmin, gmax, dma, dma_after;
    int order[6], when[6];
    bit cpu_done, fin;

    do_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_ack", ack, 0); chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0); chk("rst_addr", mem_addr, 0);

    // Single CPU read
    set_req(1, 1'b0, 32'h4, 32'h0, 2'd2); req[1] = 1'b1;
    @(negedge clk); chk("rd_gnt", gnt, 3'b010); chk("rd_setup_read", mem_read, 0);
    @(negedge clk); chk("rd_strobe", mem_read, 1); chk("rd_addr", mem_addr, 32'h4);
    chk("rd_noack", ack, 0);
    @(negedge clk); chk("rd_ack", ack, 3'b010); chk("rd_data", rdata, 32'hDEADBEEF);
    chk("rd_strobe_off", mem_read, 0);
    req[1] = 1'b0;
    @(negedge clk); chk("rd_ack_pulse", ack, 0); chk("rd_gnt_clr", gnt, 0);

    // DMA write
    set_req(0, 1'b1, 32'h0800_0010, 32'h1234_5678, 2'd2); req[0] = 1'b1;
    @(negedge clk); chk("wr_gnt", gnt, 3'b001);
    @(negedge clk); chk("wr_strobe", mem_write, 1); chk("wr_addr", mem_addr, 32'h0800_0010);
    chk("wr_data", mem_wdata, 32'h1234_5678); chk("wr_noread", mem_read, 0);
    @(negedge clk); chk("wr_ack", ack, 3'b001); chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    chk("wr_strobe_off", mem_write, 0);
    req[0] = 1'b0;
    @(negedge clk);

    // mem_ok stall during a read
    set_req(1, 1'b0, 32'h100, 32'h0, 2'd1); req[1] = 1'b1;
    @(negedge clk); chk("st_gnt", gnt, 3'b010);
    @(negedge clk); chk("st_strobe", mem_read, 1); mem_ok = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("st_hold_read", mem_read, 1); chk("st_noack", ack, 0);
      chk("st_addr", mem_addr, 32'h100);
    end
    mem_ok = 1'b1;
    @(negedge clk); chk("st_ack", ack, 3'b010); chk("st_data", rdata, 32'h0100_FEFF);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset in the middle of a sound-FIFO write
    set_req(2, 1'b1, 32'h40, 32'hAA, 2'd0); req[2] = 1'b1;
    @(negedge clk); chk("rw_gnt", gnt, 3'b100);
    @(negedge clk); chk("rw_strobe", mem_write, 1);
    #2 rst_n = 1'b0;
    #1 chk("rw_gnt_rst", gnt, 0); chk("rw_write_rst", mem_write, 0); chk("rw_ack_rst", ack, 0);
    req = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    set_req(1, 1'b0, 32'h8, 32'h0, 2'd2); set_req(2, 1'b0, 32'h40, 32'h0, 2'd2);
    req = 3'b110;
    @(negedge clk); chk("rw_ptr0_gnt", gnt, 3'b010);
    @(negedge clk); @(negedge clk); chk("rw_ack", ack, 3'b010);
    req = '0;
    @(negedge clk);

    // Round robin with all requesters held from reset
    do_reset();
    set_req(0, 1'b0, 32'h10, 0, 2'd2); set_req(1, 1'b0, 32'h20, 0, 2'd2);
    set_req(2, 1'b0, 32'h30, 0, 2'd2);
    req = 3'b111;
    nack = 0;
    for (int c = 0; c < 60 && nack < 6; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        order[nack] = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 9;
        when[nack] = c;
        nack++;
        if (nack == 6) req = '0;
      end
    end
    chk("rr_count", nack, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], k % 3);
    for (int k = 1; k < 6; k++) chk($sformatf("rr_gap%0d", k), when[k] - when[k-1], 3);
    @(negedge clk);

    // DMA locked burst versus CPU
    do_reset();
    set_req(0, 1'b0, 32'h200, 0, 2'd2); set_req(1, 1'b0, 32'h300, 0, 2'd2);
    lock[0] = 1'b1; req = 3'b011;
    dma = 0; dma_after = 0; last = -1; gmin = 1000; gmax = 0;
    cpu_done = 1'b0; fin = 1'b0; cyc = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      cyc = c;
      if (ack[0]) begin
        if (!cpu_done) begin
          if (last >= 0) begin
            if (c - last < gmin) gmin = c - last;
            if (c - last > gmax) gmax = c - last;
          end
          last = c; dma++;
        end else begin
          dma_after++; fin = 1'b1; req = '0; lock = '0;
        end
      end
      if (ack[1]) begin
        cpu_done = 1'b1; req[1] = 1'b0;
      end
    end
    chk("lk_done", fin, 1);
    chk("lk_burst_len", dma, 16);
    chk("lk_gap_min", gmin, 2);
    chk("lk_gap_max", gmax, 2);
    chk("lk_dma_again", dma_after, 1);
    if (cyc < 0) $display("cycle %0d", cyc);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
